// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for a valid/ready bus. It accepts one write or read
//   request at a time, optionally inserts WAIT_CYCLES wait states, then
//   completes the transfer with a one-cycle ready pulse. The memory is a
//   DEPTH-entry register file that is cleared on reset.
//
// Parameters
//   WIDTH        data width of wdata/rdata
//   ADDR_WIDTH   address width, DEPTH = 2**ADDR_WIDTH
//   WAIT_CYCLES  wait states before ready (0..15)
//
// Ports
//   clk    bus clock, all state on posedge
//   rst    asynchronous active-low reset
//   valid  request valid, held by the initiator until ready is seen
//   wr_rd  1 = write, 0 = read (latched at acceptance)
//   addr   word address (latched at acceptance)
//   wdata  write data (latched at acceptance)
//   ready  registered transfer-complete pulse
//   rdata  read data, valid while ready=1 on a read, held afterwards
//   busy   registered, high while in WAIT or RESP
//   err    registered one-cycle pulse when valid drops before completion
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int WIDTH       = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic                  ready,
    output logic [WIDTH-1:0]      rdata,
    output logic                  busy,
    output logic                  err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [CW-1:0]           cnt_r;
    logic [CW-1:0]           cnt_s;
    logic                    accept_s;
    logic                    commit_s;
    logic                    abort_s;
    logic                    enter_resp_s;
    logic                    rd_wr_s;
    logic [ADDR_WIDTH-1:0]   rd_addr_s;

    logic                    req_wr_r;
    logic [ADDR_WIDTH-1:0]   req_addr_r;
    logic [WIDTH-1:0]        req_wdata_r;
    logic                    ready_r;
    logic [WIDTH-1:0]        rdata_r;
    logic                    busy_r;
    logic                    err_r;
    logic [WIDTH-1:0]        mem_r [DEPTH];

    // Next-state, wait counter and transfer event decode.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        commit_s = 1'b0;
        abort_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (valid) begin
                    accept_s = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_s = ST_RESP;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = CW'(WAIT_CYCLES - 1);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (valid) begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_s = ST_RESP;
                    end else begin
                        cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end
            end
            ST_RESP: begin
                // ready is high throughout RESP, so valid alone marks completion.
                if (valid) begin
                    commit_s = req_wr_r;
                end else begin
                    abort_s = 1'b1;
                end
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // With zero wait states RESP is entered on the acceptance edge itself,
    // before the request registers hold the new request, so read the live
    // inputs in that case.
    always_comb begin
        enter_resp_s = (state_s == ST_RESP) && (state_r != ST_RESP);
        if (state_r == ST_IDLE) begin
            rd_wr_s   = wr_rd;
            rd_addr_s = addr;
        end else begin
            rd_wr_s   = req_wr_r;
            rd_addr_s = req_addr_r;
        end
    end

    // State, counter, request latch and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            req_wr_r    <= 1'b0;
            req_addr_r  <= {ADDR_WIDTH{1'b0}};
            req_wdata_r <= {WIDTH{1'b0}};
            ready_r     <= 1'b0;
            rdata_r     <= {WIDTH{1'b0}};
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                req_wr_r    <= wr_rd;
                req_addr_r  <= addr;
                req_wdata_r <= wdata;
            end
            ready_r <= (state_s == ST_RESP);
            busy_r  <= (state_s != ST_IDLE);
            err_r   <= abort_s;
            if (enter_resp_s && !rd_wr_s) begin
                rdata_r <= mem_r[rd_addr_s];
            end
        end
    end

    // Register-file storage; only a completed write updates it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (commit_s) begin
                mem_r[req_addr_r] <= req_wdata_r;
            end
        end
    end

    assign ready = ready_r;
    assign rdata = rdata_r;
    assign busy  = busy_r;
    assign err   = err_r;

endmodule
